// File: rtl/clkgen_pkg.sv
`timescale 1ns/1ps
// clkgen_pkg
// Shared constants for the clock-generation blocks.
//   GATE_STYLE_LATCH / GATE_STYLE_FLOP : legal values of the gate-style parameter
//   MAX_CE_SYNC_STAGES                 : deepest CE synchronizer supported
package clkgen_pkg;

  localparam string GATE_STYLE_LATCH   = "LATCH";
  localparam string GATE_STYLE_FLOP    = "FLOP";
  localparam int    MAX_CE_SYNC_STAGES = 3;

endpackage

// File: rtl/ce_sync.sv
`timescale 1ns/1ps
// ce_sync
// N-stage synchronizer for a clock-enable, cleared by an asynchronous
// active-low reset. Only instantiated when at least one stage is wanted.
// Ports:
//   clk   in  1  sampling clock (rising edge)
//   rst_n in  1  asynchronous active-low clear of every stage
//   d     in  1  asynchronous enable
//   q     out 1  enable after STAGES rising edges of clk
module ce_sync
  import clkgen_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (STAGES < 1 || STAGES > MAX_CE_SYNC_STAGES) begin : g_bad_stages
      $fatal(1, "ce_sync: STAGES must be 1..%0d", MAX_CE_SYNC_STAGES);
    end
  endgenerate

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift chain: stage 0 takes the raw enable, each later stage its predecessor.
  always_comb begin
    sync_d    = '0;
    sync_d[0] = d;
    for (int s = 1; s < STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/bufgce_gate.sv
`timescale 1ns/1ps
// bufgce_gate
// Glitch-free gated clock buffer with clock enable. O follows I only for
// whole high phases during which the enable is applied; the enable may only
// change while the (effective) clock is low, so O never carries a runt pulse
// except when RESETN_spi is asserted mid-high-phase.
// Ports:
//   I          in  1  clock to be gated (the only clock of this block)
//   RESETN_spi in  1  asynchronous active-low reset
//   CE         in  1  clock enable, polarity set by IS_CE_INVERTED
//   O          out 1  gated clock
//   CE_ACTIVE  out 1  enable currently applied to the gate
module bufgce_gate
  import clkgen_pkg::*;
#(
  parameter int    CE_SYNC_STAGES = 0,
  parameter bit    IS_CE_INVERTED = 1'b0,
  parameter bit    IS_I_INVERTED  = 1'b0,
  parameter string GATE_STYLE     = "LATCH"
) (
  input  logic I,
  input  logic RESETN_spi,
  input  logic CE,
  output logic O,
  output logic CE_ACTIVE
);

  generate
    if (CE_SYNC_STAGES < 0 || CE_SYNC_STAGES > MAX_CE_SYNC_STAGES) begin : g_bad_stages
      $fatal(1, "bufgce_gate: CE_SYNC_STAGES must be 0..%0d", MAX_CE_SYNC_STAGES);
    end
    if (GATE_STYLE != GATE_STYLE_LATCH && GATE_STYLE != GATE_STYLE_FLOP) begin : g_bad_style
      $fatal(1, "bufgce_gate: GATE_STYLE must be \"LATCH\" or \"FLOP\"");
    end
  endgenerate

  logic i_n;
  logic ce_n;
  logic ce_s;
  logic en_d;
  logic en_q;

  assign i_n  = I ^ IS_I_INVERTED;
  assign ce_n = CE ^ IS_CE_INVERTED;

  // With zero stages CE is expected to be synchronous to the falling edge
  // of i_n already, so it goes straight to the gate.
  generate
    if (CE_SYNC_STAGES == 0) begin : g_no_sync
      assign ce_s = ce_n;
    end else begin : g_sync
      ce_sync #(
        .STAGES (CE_SYNC_STAGES)
      ) u_ce_sync (
        .clk   (i_n),
        .rst_n (RESETN_spi),
        .d     (ce_n),
        .q     (ce_s)
      );
    end
  endgenerate

  always_comb begin
    en_d = ce_s;
  end

  // The gate enable may only move while i_n is low. A low-transparent latch
  // lets an enable that arrives during the low phase open the very next high
  // phase; the negedge flop commits only at the falling edge.
  generate
    if (GATE_STYLE == GATE_STYLE_FLOP) begin : g_flop
      always_ff @(negedge i_n or negedge RESETN_spi) begin
        if (!RESETN_spi) begin
          en_q <= 1'b0;
        end else begin
          en_q <= en_d;
        end
      end
    end else begin : g_latch
      always_latch begin
        if (!RESETN_spi) begin
          en_q <= 1'b0;
        end else if (!i_n) begin
          en_q <= en_d;
        end
      end
    end
  endgenerate

  assign O         = i_n & en_q;
  assign CE_ACTIVE = en_q;

`ifndef SYNTHESIS
  always @(CE or RESETN_spi) begin
    if (RESETN_spi === 1'b1 && $isunknown(CE)) begin
      $error("bufgce_gate: CE is X/Z while out of reset");
    end
  end
`endif

endmodule

// File: tb/tb_bufgce_gate.sv
`timescale 1ns/1ps
// tb_bufgce_gate
// Six gate instances share I, CE and RESETN_spi: latch/flop styles with
// 0 and 2 synchronizer stages, a CE-inverted instance and an I-inverted
// instance. The reference treats CE as a per-cycle history: the enable for
// a high phase is the CE value that was present N cycles earlier, and any
// CE value captured before a reset release counts as 0.
module tb_bufgce_gate;

  localparam int R_NONE  = 0;
  localparam int R_HOLD  = 1;
  localparam int R_REL   = 2;
  localparam int R_PULSE = 3;

  logic I;
  logic RESETN_spi;
  logic CE;

  logic [3:0] o_main;
  logic [3:0] act_main;
  logic       o_cinv, act_cinv;
  logic       o_iinv, act_iinv;

  bufgce_gate #(.CE_SYNC_STAGES(0), .GATE_STYLE("LATCH")) u_l0 (
    .I(I), .RESETN_spi(RESETN_spi), .CE(CE), .O(o_main[0]), .CE_ACTIVE(act_main[0]));
  bufgce_gate #(.CE_SYNC_STAGES(2), .GATE_STYLE("LATCH")) u_l2 (
    .I(I), .RESETN_spi(RESETN_spi), .CE(CE), .O(o_main[1]), .CE_ACTIVE(act_main[1]));
  bufgce_gate #(.CE_SYNC_STAGES(0), .GATE_STYLE("FLOP")) u_f0 (
    .I(I), .RESETN_spi(RESETN_spi), .CE(CE), .O(o_main[2]), .CE_ACTIVE(act_main[2]));
  bufgce_gate #(.CE_SYNC_STAGES(2), .GATE_STYLE("FLOP")) u_f2 (
    .I(I), .RESETN_spi(RESETN_spi), .CE(CE), .O(o_main[3]), .CE_ACTIVE(act_main[3]));
  bufgce_gate #(.CE_SYNC_STAGES(0), .IS_CE_INVERTED(1'b1), .GATE_STYLE("LATCH")) u_cinv (
    .I(I), .RESETN_spi(RESETN_spi), .CE(CE), .O(o_cinv), .CE_ACTIVE(act_cinv));
  bufgce_gate #(.CE_SYNC_STAGES(0), .IS_I_INVERTED(1'b1), .GATE_STYLE("LATCH")) u_iinv (
    .I(I), .RESETN_spi(RESETN_spi), .CE(CE), .O(o_iinv), .CE_ACTIVE(act_iinv));

  initial begin
    I = 1'b0;
    forever #5 I = ~I;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_from = 1000000;
  bit ce_hist [0:1023];

  int    stg [4] = '{0, 2, 0, 2};
  string nm  [4] = '{"l0", "l2", "f0", "f2"};

  task automatic check(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %0b want %0b", name, cyc, got, want);
    end
  endtask

  // Enable applied during high phase c for a gate with n sync stages.
  function automatic bit exp_en(input int c, input int n, input bit inv);
    int idx;
    idx = c - 1 - n;
    if (idx < 0 || idx < valid_from) return 1'b0;
    return ce_hist[idx] ^ inv;
  endfunction

  // One I cycle: sample early high (T+1), change CE/reset (T+2),
  // sample late high (T+3), sample low phase (T+7).
  task automatic run_cycle(input bit ce, input int ract,
                           output logic [3:0] early_o, output logic [3:0] low_act);
    bit exp_hi [4];
    bit exp_ci;
    @(posedge I);
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_hi[i] = exp_en(cyc, stg[i], 1'b0);
      check({nm[i], "_o_early"}, o_main[i], exp_hi[i]);
    end
    exp_ci = exp_en(cyc, 0, 1'b1);
    check("cinv_o_early", o_cinv, exp_ci);
    check("iinv_o_high", o_iinv, 1'b0);
    early_o = o_main;
    #1;
    CE = ce;
    ce_hist[cyc] = ce;
    case (ract)
      R_HOLD: begin RESETN_spi = 1'b0; valid_from = cyc + 1; end
      R_REL:  begin RESETN_spi = 1'b1; valid_from = cyc; end
      R_PULSE: begin
        RESETN_spi = 1'b0;
        valid_from = cyc + 1;
        fork
          begin #12 RESETN_spi = 1'b1; end
        join_none
      end
      default: ;
    endcase
    #1;
    for (int i = 0; i < 4; i++) begin
      check({nm[i], "_o_late"}, o_main[i], exp_hi[i] & RESETN_spi);
    end
    check("cinv_o_late", o_cinv, exp_ci & RESETN_spi);
    #4;
    for (int i = 0; i < 4; i++) begin
      check({nm[i], "_o_low"}, o_main[i], 1'b0);
      check({nm[i], "_ce_active"}, act_main[i], exp_en(cyc + 1, stg[i], 1'b0));
    end
    check("cinv_o_low", o_cinv, 1'b0);
    check("cinv_ce_active", act_cinv, exp_en(cyc + 1, 0, 1'b1));
    check("iinv_o", o_iinv, exp_en(cyc + 1, 0, 1'b0));
    check("iinv_ce_active", act_iinv, exp_en(cyc + 1, 0, 1'b0));
    low_act = act_main;
    $display("cycle %0d ce=%0b rst_n=%0b o_early=%b act=%b cinv=%0b iinv=%0b",
             cyc, ce, RESETN_spi, early_o, low_act, act_cinv, o_iinv);
    cyc++;
  endtask

  typedef struct {
    bit ce;
    int ract;
    bit exp_o;
    bit exp_act;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [3:0] eo, la;
    int pulses [4];
    int first  [4];
    int burst_start;
    bit ce_r;
    int last_ract;

    RESETN_spi = 1'b0;
    CE = 1'b0;

    // Reset with CE high, release, drop CE mid-high, raise CE mid-high,
    // 12 ns reset pulse mid-burst. Expectations are for the latch gate with
    // no synchronizer: O in the early high sample, CE_ACTIVE in the low phase.
    tbl[0]  = '{1'b1, R_HOLD,  1'b0, 1'b0};
    tbl[1]  = '{1'b1, R_HOLD,  1'b0, 1'b0};
    tbl[2]  = '{1'b1, R_HOLD,  1'b0, 1'b0};
    tbl[3]  = '{1'b1, R_HOLD,  1'b0, 1'b0};
    tbl[4]  = '{1'b1, R_REL,   1'b0, 1'b1};
    tbl[5]  = '{1'b1, R_NONE,  1'b1, 1'b1};
    tbl[6]  = '{1'b0, R_NONE,  1'b1, 1'b0};
    tbl[7]  = '{1'b0, R_NONE,  1'b0, 1'b0};
    tbl[8]  = '{1'b1, R_NONE,  1'b0, 1'b1};
    tbl[9]  = '{1'b1, R_NONE,  1'b1, 1'b1};
    tbl[10] = '{1'b1, R_PULSE, 1'b1, 1'b0};
    tbl[11] = '{1'b1, R_NONE,  1'b0, 1'b1};
    tbl[12] = '{1'b1, R_NONE,  1'b1, 1'b1};
    tbl[13] = '{1'b0, R_NONE,  1'b1, 1'b0};

    for (int r = 0; r < 14; r++) begin
      run_cycle(tbl[r].ce, tbl[r].ract, eo, la);
      check("tbl_l0_o", eo[0], tbl[r].exp_o);
      check("tbl_l0_ce_active", la[0], tbl[r].exp_act);
    end

    for (int r = 0; r < 5; r++) run_cycle(1'b0, R_NONE, eo, la);

    // Burst: 40 cycles of CE, then idle long enough to drain the synchronizers.
    burst_start = cyc;
    for (int i = 0; i < 4; i++) begin
      pulses[i] = 0;
      first[i]  = -1;
    end
    for (int r = 0; r < 50; r++) begin
      run_cycle(r < 40, R_NONE, eo, la);
      for (int i = 0; i < 4; i++) begin
        if (eo[i]) begin
          pulses[i]++;
          if (first[i] < 0) first[i] = cyc - 1;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      check({nm[i], "_burst_pulses"}, 1'(pulses[i] == 40), 1'b1);
      check({nm[i], "_first_pulse_cycle"}, 1'(first[i] == burst_start + 1 + stg[i]), 1'b1);
      if (pulses[i] != 40 || first[i] != burst_start + 1 + stg[i])
        $display("  %s pulses=%0d first=%0d expected 40 at %0d",
                 nm[i], pulses[i], first[i], burst_start + 1 + stg[i]);
    end

    // Randomized CE runs with occasional mid-burst reset pulses.
    ce_r = 1'b0;
    last_ract = R_NONE;
    for (int r = 0; r < 300; r++) begin
      int ract;
      if ($urandom_range(0, 3) == 0) ce_r = ~ce_r;
      ract = R_NONE;
      if (last_ract != R_PULSE && $urandom_range(0, 59) == 0) ract = R_PULSE;
      run_cycle(ce_r, ract, eo, la);
      last_ract = ract;
    end
    for (int r = 0; r < 3; r++) run_cycle(1'b1, R_NONE, eo, la);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
